// File: rtl/riscv_apb_arbiter.sv
// riscv_apb_arbiter: shares one APB memory port between instruction fetch (port 0, IF) and load/store (port 1, DM).
// Latency: request seen in IDLE -> psel_o next cycle, penable_o the cycle after; memory pready is returned combinationally.
// Backpressure: the non-granted requester sees pready=0; memory wait states stall the granted one.
// Optional macro RISCV_APB_ARB_RR_EN selects round-robin arbitration instead of DM priority with a starvation guard.
module riscv_apb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_psel_i,
    input  logic        if_penable_i,
    input  logic [31:0] if_paddr_i,
    output logic        if_pready_o,
    output logic [31:0] if_prdata_o,
    input  logic        dm_psel_i,
    input  logic        dm_penable_i,
    input  logic [31:0] dm_paddr_i,
    input  logic        dm_pwrite_i,
    input  logic [31:0] dm_pwdata_i,
    output logic        dm_pready_o,
    output logic [31:0] dm_prdata_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic [31:0] paddr_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        any_req;
    logic        win_dm;
    logic        in_access;

`ifdef RISCV_APB_ARB_RR_EN
    logic        last_dm_q, last_dm_d;
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0]  starve_cnt_q, starve_cnt_d;
`endif

    // penable from the requesters is redundant: the arbiter regenerates the APB phases itself.
    logic unused_penable;
    assign unused_penable = if_penable_i ^ dm_penable_i;

    assign any_req = if_psel_i | dm_psel_i;

    always_comb begin
        win_dm = dm_psel_i;
        if (if_psel_i && dm_psel_i) begin
`ifdef RISCV_APB_ARB_RR_EN
            win_dm = ~last_dm_q;
`else
            win_dm = (starve_cnt_q != STARVE_MAX);
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
`ifdef RISCV_APB_ARB_RR_EN
        last_dm_d = last_dm_q;
`else
        starve_cnt_d = starve_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d   = ST_SETUP;
                    grant_d   = win_dm;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = win_dm ? dm_paddr_i : if_paddr_i;
                    pwrite_d  = win_dm & dm_pwrite_i;
                    pwdata_d  = win_dm ? dm_pwdata_i : 32'd0;
`ifdef RISCV_APB_ARB_RR_EN
                    last_dm_d = win_dm;
`else
                    // IF only ever loses on a tie, so a DM win with IF requesting is a loss for IF.
                    if (!win_dm) begin
                        starve_cnt_d = 4'd0;
                    end else if (if_psel_i && (starve_cnt_q != STARVE_MAX)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
`endif
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = 32'd0;
                    pwdata_d  = 32'd0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
                paddr_d   = 32'd0;
                pwdata_d  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= GNT_IF;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 32'd0;
            pwdata_q  <= 32'd0;
`ifdef RISCV_APB_ARB_RR_EN
            last_dm_q <= GNT_DM;
`else
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
`ifdef RISCV_APB_ARB_RR_EN
            last_dm_q <= last_dm_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // A transfer cut short by reset must not report completion upstream.
    assign in_access = (state_q == ST_ACCESS) & ~reset;

    assign if_pready_o = in_access & (grant_q == GNT_IF) & pready_i;
    assign dm_pready_o = in_access & (grant_q == GNT_DM) & pready_i;
    assign if_prdata_o = prdata_i;
    assign dm_prdata_o = prdata_i;

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign paddr_o   = paddr_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;

endmodule
